add_32: RTL and testbench

ADD_32 -- requirements
Module: add_32

---
 rtl/add_32_pkg.sv | 28 ++
 rtl/add_32_cla4.sv | 30 +++
 rtl/add_32.sv | 94 +++++++++
 tb/tb_add_32.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/add_32_pkg.sv
// Shared constants, flag bundle and flag derivation for the add_32 adder.
package add_32_pkg;

    localparam int ADD_W      = 32;
    localparam int CLA_W      = 4;
    localparam int NUM_GROUPS = ADD_W / CLA_W;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } add_flags_t;

    // Overflow is judged on the operand actually fed to the adder (b already inverted for subtract).
    function automatic add_flags_t make_flags(
        input logic             carry,
        input logic [ADD_W-1:0] op_a,
        input logic [ADD_W-1:0] op_b,
        input logic [ADD_W-1:0] sum
    );
        add_flags_t f;
        f.cout = carry;
        f.ovf  = (op_a[ADD_W-1] == op_b[ADD_W-1]) && (sum[ADD_W-1] != op_a[ADD_W-1]);
        f.zero = ~|sum;
        return f;
    endfunction

endpackage

// File: rtl/add_32_cla4.sv
// 4-bit carry-lookahead slice exporting group propagate/generate for the next lookahead level.
module add_32_cla4 (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s,
    output logic       p,
    output logic       g
);

    logic [3:0] bit_p;
    logic [3:0] bit_g;
    logic [3:0] carry;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Every internal carry is a flat sum of products of cin and the bit p/g terms.
    assign carry[0] = cin;
    assign carry[1] = bit_g[0] | (bit_p[0] & cin);
    assign carry[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
    assign carry[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
                    | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

    assign s = bit_p ^ carry;
    assign p = &bit_p;
    assign g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
             | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);

endmodule

// File: rtl/add_32.sv
// 32-bit add (and, with ADD_32_SUB_EN defined, subtract) built from eight CLA slices,
// with a combinational result and an optional registered result/flag stage.
module add_32
    import add_32_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             in_valid,
`ifdef ADD_32_SUB_EN
    input  logic             sub,
`endif
    output logic [ADD_W-1:0] c,
    output logic [ADD_W-1:0] c_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             out_valid
);

    logic                  sub_eff;
    logic [ADD_W-1:0]      b_eff;
    logic [ADD_W-1:0]      sum;
    logic [NUM_GROUPS:0]   grp_carry;
    logic [NUM_GROUPS-1:0] grp_p;
    logic [NUM_GROUPS-1:0] grp_g;
    add_flags_t            flags_next;

`ifdef ADD_32_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Subtract is a + ~b + 1: invert b and inject the 1 as the chain's carry-in.
    assign b_eff        = b ^ {ADD_W{sub_eff}};
    assign grp_carry[0] = sub_eff;

    generate
        for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_slice
            add_32_cla4 u_cla4 (
                .cin (grp_carry[gi]),
                .a   (a[gi*CLA_W +: CLA_W]),
                .b   (b_eff[gi*CLA_W +: CLA_W]),
                .s   (sum[gi*CLA_W +: CLA_W]),
                .p   (grp_p[gi]),
                .g   (grp_g[gi])
            );
            assign grp_carry[gi+1] = grp_g[gi] | (grp_p[gi] & grp_carry[gi]);
        end
    endgenerate

    assign c          = sum;
    assign flags_next = make_flags(grp_carry[NUM_GROUPS], a, b_eff, sum);

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [ADD_W-1:0] c_q_reg;
            add_flags_t       flags_reg;
            logic             valid_reg;

            // Reset wins over in_valid, so an input presented during reset is dropped.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    c_q_reg   <= '0;
                    flags_reg <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= in_valid;
                    if (in_valid) begin
                        c_q_reg   <= sum;
                        flags_reg <= flags_next;
                    end
                end
            end

            assign c_q       = c_q_reg;
            assign cout_q    = flags_reg.cout;
            assign ovf_q     = flags_reg.ovf;
            assign zero_q    = flags_reg.zero;
            assign out_valid = valid_reg;
        end else begin : g_comb_out
            assign c_q       = sum;
            assign cout_q    = flags_next.cout;
            assign ovf_q     = flags_next.ovf;
            assign zero_q    = flags_next.zero;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_add_32.sv
// Self-checking bench for add_32 (REG_OUT=1); subtract cases run only when ADD_32_SUB_EN is defined.
module tb_add_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        sub;
    logic [31:0] c;
    logic [31:0] c_q;
    logic        cout_q;
    logic        ovf_q;
    logic        zero_q;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    // Expected registered state, maintained by the bench.
    logic [31:0] exp_cq;
    logic        exp_co;
    logic        exp_ov;
    logic        exp_z;

    always #5 clk = ~clk;

    add_32 #(.REG_OUT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
`ifdef ADD_32_SUB_EN
        .sub       (sub),
`endif
        .c         (c),
        .c_q       (c_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .zero_q    (zero_q),
        .out_valid (out_valid)
    );

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic void model(input logic [31:0] op_a, input logic [31:0] op_b, input logic do_sub,
                                  output logic [31:0] r, output logic co, output logic ov, output logic z);
        logic [63:0] wide;
        longint      sa;
        longint      sb;
        longint      sr;
        sa = longint'($signed(op_a));
        sb = longint'($signed(op_b));
        if (do_sub) begin
            wide = {32'd0, op_a} - {32'd0, op_b};
            co   = (op_a >= op_b);
            sr   = sa - sb;
        end else begin
            wide = {32'd0, op_a} + {32'd0, op_b};
            co   = wide[32];
            sr   = sa + sb;
        end
        r  = wide[31:0];
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        z  = (r == 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One transaction: drive inputs, check c combinationally, then check registered outputs after the edge.
    task automatic apply(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tv);
        logic [31:0] r;
        logic        co, ov, z;
`ifndef ADD_32_SUB_EN
        ts = 1'b0;
`endif
        a = ta; b = tb; sub = ts; in_valid = tv;
        model(ta, tb, ts, r, co, ov, z);
        #1;
        chk("c", c, r);
        @(posedge clk);
        #1;
        if (tv) begin
            exp_cq = r; exp_co = co; exp_ov = ov; exp_z = z;
        end
        chk("c_q", c_q, exp_cq);
        chk("cout_q", {31'd0, cout_q}, {31'd0, exp_co});
        chk("ovf_q", {31'd0, ovf_q}, {31'd0, exp_ov});
        chk("zero_q", {31'd0, zero_q}, {31'd0, exp_z});
        chk("out_valid", {31'd0, out_valid}, {31'd0, tv});
        $display("txn a=%h b=%h sub=%0d v=%0d c=%h c_q=%h cout=%0d ovf=%0d zero=%0d ov=%0d",
                 ta, tb, ts, tv, c, c_q, cout_q, ovf_q, zero_q, out_valid);
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; sub = 1'b0; in_valid = 1'b0;
        exp_cq = '0; exp_co = 1'b0; exp_ov = 1'b0; exp_z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c_q", c_q, 32'd0);
        chk("rst_flags", {29'd0, cout_q, ovf_q, zero_q}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // Directed corner cases
        apply(32'd0, 32'd0, 1'b0, 1'b1);
        apply(32'd100, 32'd100, 1'b0, 1'b1);
        apply(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        apply(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        apply(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
`ifdef ADD_32_SUB_EN
        apply(32'd5, 32'd7, 1'b1, 1'b1);
        apply(32'd7, 32'd5, 1'b1, 1'b1);
        apply(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        apply(32'd9, 32'd9, 1'b1, 1'b1);
`endif

        // Reset coincident with a valid input: input dropped, c still live
        a = 32'd100; b = 32'd100; sub = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
        #1;
        chk("rstv_c_before", c, 32'd200);
        @(posedge clk);
        #1;
        chk("rstv_c_q", c_q, 32'd0);
        chk("rstv_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstv_c_after", c, 32'd200);
        $display("txn reset-with-valid a=%h b=%h c=%h c_q=%h ov=%0d", a, b, c, c_q, out_valid);
        exp_cq = '0; exp_co = 1'b0; exp_ov = 1'b0; exp_z = 1'b0;
        rst_n = 1'b1;

        // Back-to-back stream then idle; c_q must hold the last value
        apply(32'd1, 32'd1, 1'b0, 1'b1);
        apply(32'd2, 32'd2, 1'b0, 1'b1);
        apply(32'd3, 32'd3, 1'b0, 1'b1);
        apply(32'd50, 32'd60, 1'b0, 1'b0);
        chk("b2b_hold", c_q, 32'd6);
        apply(32'd0, 32'd0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            logic        rs, rv;
            ra = $urandom;
            rb = (i % 8 == 0) ? (32'd0 - ra) : $urandom;
            rs = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            apply(ra, rb, rs, rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
